multicycle_ctrl_hs: RTL

//  Next-gen multicycle RV32I control FSM with handshaked instruction/data memory.

---
 rtl/multicycle_ctrl_hs.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle RV32I control FSM with handshaked instruction/data memory and a sticky trap.
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        dmem_ready,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [5:0] {
    S_IF   = 6'b000001,
    S_ID   = 6'b000010,
    S_EX   = 6'b000100,
    S_MEM  = 6'b001000,
    S_WB   = 6'b010000,
    S_TRAP = 6'b100000
  } state_t;

  typedef enum logic [2:0] {C_OP, C_IMM, C_LW, C_SW, C_BR, C_ILL} iclass_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_LESS = 4'b0111;
  localparam logic [3:0] ALU_LSR  = 4'b1000;
  localparam logic [3:0] ALU_LSL  = 4'b1001;
  localparam logic [3:0] ALU_ASR  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state;
  logic [31:0]      ir;
  logic [TMO_W-1:0] tmo_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign funct3         = ir[14:12];
  assign funct7         = ir[31:25];
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  iclass_t    iclass;
  logic       legal;
  logic [3:0] dec_alu;
  logic       dec_src;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    iclass  = C_ILL;
    legal   = 1'b0;
    dec_alu = ALU_ADD;
    dec_src = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        iclass = C_OP;
        unique case (funct3)
          3'b000: begin dec_alu = ir[30] ? ALU_SUB : ALU_ADD;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000); end
          3'b001: begin dec_alu = ALU_LSL;  legal = (funct7 == 7'b0000000); end
          3'b010: begin dec_alu = ALU_LESS; legal = (funct7 == 7'b0000000); end
          3'b100: begin dec_alu = ALU_XOR;  legal = (funct7 == 7'b0000000); end
          3'b101: begin dec_alu = ir[30] ? ALU_ASR : ALU_LSR;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000); end
          3'b110: begin dec_alu = ALU_OR;   legal = (funct7 == 7'b0000000); end
          3'b111: begin dec_alu = ALU_AND;  legal = (funct7 == 7'b0000000); end
          default: legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        iclass  = C_IMM;
        dec_src = 1'b1;
        unique case (funct3)
          3'b000: begin dec_alu = ALU_ADD;  legal = 1'b1; end
          3'b001: begin dec_alu = ALU_LSL;  legal = (funct7 == 7'b0000000); end
          3'b010: begin dec_alu = ALU_LESS; legal = 1'b1; end
          3'b100: begin dec_alu = ALU_XOR;  legal = 1'b1; end
          3'b101: begin dec_alu = ir[30] ? ALU_ASR : ALU_LSR;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000); end
          3'b110: begin dec_alu = ALU_OR;   legal = 1'b1; end
          3'b111: begin dec_alu = ALU_AND;  legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OPC_LW: begin iclass = C_LW; dec_src = 1'b1; legal = (funct3 == 3'b010); end
      OPC_SW: begin iclass = C_SW; dec_src = 1'b1; legal = (funct3 == 3'b010); end
      OPC_BR: begin iclass = C_BR; dec_alu = ALU_SUB; legal = (funct3[2:1] == 2'b00); end
      default: iclass = C_ILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IF;
      ir         <= '0;
      tmo_cnt    <= '0;
      trap_cause <= 2'b00;
    end else begin
      unique case (state)
        S_IF: if (instr_valid) begin
          ir    <= instr;
          state <= S_ID;
        end
        S_ID: if (legal) state <= S_EX;
        else begin
          state      <= S_TRAP;
          trap_cause <= 2'b01;
        end
        S_EX: begin
          tmo_cnt <= '0;
          state   <= (iclass == C_LW || iclass == C_SW) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) state <= S_WB;
          else if (MEM_TIMEOUT != 0 && tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
            state      <= S_TRAP;
            trap_cause <= 2'b10;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        S_WB:    state <= S_IF;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Outputs depend only on registered state and ir (plus Zero in WB), so reset clears them at once.
  always_comb begin
    logic busy;
    busy     = (state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB);
    ALUSrc   = busy && dec_src;
    ALUCtrl  = busy ? dec_alu : 4'b0000;
    loadPC   = (state == S_WB);
    RegWrite = (state == S_WB) && (iclass == C_OP || iclass == C_IMM || iclass == C_LW);
    MemToReg = (state == S_WB) && (iclass == C_LW);
    PCSrc    = (state == S_WB) && (iclass == C_BR) && (funct3[0] ? ~Zero : Zero);
    MemRead  = (state == S_MEM) && (iclass == C_LW);
    MemWrite = (state == S_MEM) && (iclass == C_SW);
    trap     = (state == S_TRAP);
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (state == S_WB)   instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
